// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared types and constants for the EX-stage ALU control path.
//   - op_e      : 5-bit operation codes driven to the ALU / MDU
//   - state_e   : sequencer FSM states
//   - ALUOP_*   : main-decoder alu_op field values
//   - F7_*      : funct7 patterns that select base / alternate / RV32M ops
//   - base_op() : funct3 -> base integer op (funct7 = 0000000 semantics)
//   - is_mdu()  : true for ops executed by the multiply/divide unit
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

    typedef enum logic [4:0] {
        OP_AND    = 5'h00,
        OP_OR     = 5'h01,
        OP_ADD    = 5'h02,
        OP_XOR    = 5'h03,
        OP_SLL    = 5'h04,
        OP_SRL    = 5'h05,
        OP_SUB    = 5'h06,
        OP_SRA    = 5'h07,
        OP_SLT    = 5'h08,
        OP_SLTU   = 5'h09,
        OP_PASSB  = 5'h0A,
        OP_BEQ    = 5'h10,
        OP_BNE    = 5'h11,
        OP_BLT    = 5'h14,
        OP_BGE    = 5'h15,
        OP_BLTU   = 5'h16,
        OP_BGEU   = 5'h17,
        OP_MUL    = 5'h18,
        OP_MULH   = 5'h19,
        OP_MULHSU = 5'h1A,
        OP_MULHU  = 5'h1B,
        OP_DIV    = 5'h1C,
        OP_DIVU   = 5'h1D,
        OP_REM    = 5'h1E,
        OP_REMU   = 5'h1F
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_PASSB  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Integer op selected by funct3 when funct7 carries no modifier.
    function automatic op_e base_op(input logic [2:0] funct3);
        op_e op;
        case (funct3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    // MDU ops occupy the 0x18..0x1F block.
    function automatic logic is_mdu(input op_e op);
        return (op[4:3] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// -----------------------------------------------------------------------------
// alu_op_decode
//   Pure combinational decode of the ALU control fields.
//   Ports:
//     alu_op     in  2  main-decoder class (mem / branch / arith / passb)
//     is_imm     in  1  1 = I-type arithmetic
//     funct7     in  7  instr[31:25]
//     funct3     in  3  instr[14:12]
//     operation  out 5  decoded op (ADD whenever the encoding is illegal)
//     illegal    out 1  encoding not recognised
//     multicycle out 1  op is executed by the MDU
//   Parameter ENABLE_M: nonzero decodes funct7=0000001 R-type as RV32M.
// -----------------------------------------------------------------------------
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [1:0] alu_op,
    input  logic       is_imm,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output op_e        operation,
    output logic       illegal,
    output logic       multicycle
);

    op_e  dec_op;
    logic bad;

    always_comb begin
        dec_op = OP_ADD;
        bad    = 1'b0;
        case (alu_op)
            ALUOP_MEM: begin
                dec_op = OP_ADD;
            end
            ALUOP_PASSB: begin
                dec_op = OP_PASSB;
            end
            ALUOP_BRANCH: begin
                // funct3 010/011 are unassigned in the branch space.
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    bad = 1'b1;
                end else begin
                    dec_op = op_e'({2'b10, funct3});
                end
            end
            default: begin
                if (is_imm) begin
                    // funct7 is immediate data except for the shift encodings.
                    case (funct3)
                        3'b001: begin
                            if (funct7 == F7_BASE) dec_op = OP_SLL;
                            else                   bad    = 1'b1;
                        end
                        3'b101: begin
                            if (funct7 == F7_BASE)     dec_op = OP_SRL;
                            else if (funct7 == F7_ALT) dec_op = OP_SRA;
                            else                       bad    = 1'b1;
                        end
                        default: begin
                            // ADDI ignores bit 30: never SUB.
                            dec_op = base_op(funct3);
                        end
                    endcase
                end else begin
                    case (funct7)
                        F7_BASE: begin
                            dec_op = base_op(funct3);
                        end
                        F7_ALT: begin
                            if (funct3 == 3'b000)      dec_op = OP_SUB;
                            else if (funct3 == 3'b101) dec_op = OP_SRA;
                            else                       bad    = 1'b1;
                        end
                        F7_MULDIV: begin
                            if (ENABLE_M != 0) dec_op = op_e'({2'b11, funct3});
                            else               bad    = 1'b1;
                        end
                        default: begin
                            bad = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    assign illegal    = bad;
    assign operation  = bad ? OP_ADD : dec_op;
    assign multicycle = !bad && is_mdu(dec_op);

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//   Registered, valid/ready-handshaked ALU control decode for the EX stage.
//   Single-cycle ops appear one cycle after accept; MUL*/DIV* ops pulse
//   mdu_start, hold the stage for MUL_LAT / DIV_LAT cycles, then present the
//   result. flush drops any in-flight op and pulses mdu_abort if the MDU was
//   busy.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     flush               pipeline flush (highest priority)
//     in_valid/in_ready   request handshake
//     alu_op,is_imm,
//     funct7,funct3       decode fields
//     out_valid/out_ready result handshake
//     operation [OP_W]    op code (bits above [4] are zero)
//     illegal,multicycle  decode flags
//     mdu_start,mdu_abort one-cycle MDU control pulses
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic            is_imm,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] operation,
    output logic            illegal,
    output logic            multicycle,
    output logic            mdu_start,
    output logic            mdu_abort
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Counter preload values: the accept cycle itself counts as one.
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    op_e  dec_op;
    logic dec_illegal;
    logic dec_multicycle;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .alu_op     (alu_op),
        .is_imm     (is_imm),
        .funct7     (funct7),
        .funct3     (funct3),
        .operation  (dec_op),
        .illegal    (dec_illegal),
        .multicycle (dec_multicycle)
    );

    state_e           state_reg,      state_next;
    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic             out_valid_reg,  out_valid_next;
    op_e              op_reg,         op_next;
    logic             illegal_reg,    illegal_next;
    logic             multi_reg,      multi_next;
    logic             mdu_start_reg,  mdu_start_next;
    logic             mdu_abort_reg,  mdu_abort_next;

    logic             accept;
    logic [CNT_W-1:0] lat_cnt;

    // A new request is taken only when idle, the output slot is free (or
    // being drained this cycle), and no flush is in progress.
    assign in_ready = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // funct3[2] splits the MDU block into MUL* (0) and DIV*/REM* (1).
    assign lat_cnt  = dec_op[2] ? DIV_CNT : MUL_CNT;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_valid_next = out_valid_reg;
        op_next        = op_reg;
        illegal_next   = illegal_reg;
        multi_next     = multi_reg;
        mdu_start_next = 1'b0;
        mdu_abort_next = 1'b0;

        if (flush) begin
            out_valid_next = 1'b0;
            state_next     = ST_IDLE;
            cnt_next       = '0;
            mdu_abort_next = (state_reg == ST_BUSY);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_next      = dec_op;
                        illegal_next = dec_illegal;
                        multi_next   = dec_multicycle;
                        if (dec_multicycle) begin
                            mdu_start_next = 1'b1;
                            if (lat_cnt == '0) begin
                                // Single-cycle MDU: result ready like a plain op.
                                out_valid_next = 1'b1;
                            end else begin
                                out_valid_next = 1'b0;
                                state_next     = ST_BUSY;
                                cnt_next       = lat_cnt;
                            end
                        end else begin
                            out_valid_next = 1'b1;
                        end
                    end else if (out_valid_reg && out_ready) begin
                        out_valid_next = 1'b0;
                    end
                end
                ST_BUSY: begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        out_valid_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            op_reg        <= OP_AND;
            illegal_reg   <= 1'b0;
            multi_reg     <= 1'b0;
            mdu_start_reg <= 1'b0;
            mdu_abort_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
            op_reg        <= op_next;
            illegal_reg   <= illegal_next;
            multi_reg     <= multi_next;
            mdu_start_reg <= mdu_start_next;
            mdu_abort_reg <= mdu_abort_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign illegal    = illegal_reg;
    assign multicycle = multi_reg;
    assign mdu_start  = mdu_start_reg;
    assign mdu_abort  = mdu_abort_reg;

    generate
        if (OP_W > 5) begin : g_op_pad
            assign operation = {{(OP_W-5){1'b0}}, op_reg};
        end else begin : g_op_exact
            assign operation = op_reg;
        end
    endgenerate

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int OP_W    = 5;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: RV32M enabled, default latencies.
    logic            reset, flush, in_valid, out_ready, is_imm;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic            in_ready, out_valid, illegal, multicycle, mdu_start, mdu_abort;
    logic [OP_W-1:0] operation;

    // Second instance: RV32M disabled, wider op code.
    logic            b_flush, b_in_valid, b_out_ready, b_is_imm;
    logic [1:0]      b_alu_op;
    logic [6:0]      b_funct7;
    logic [2:0]      b_funct3;
    logic            b_in_ready, b_out_valid, b_illegal, b_multicycle, b_mdu_start, b_mdu_abort;
    logic [5:0]      b_operation;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_sequencer #(
        .OP_W(OP_W), .ENABLE_M(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .is_imm(is_imm), .funct7(funct7), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .operation(operation), .illegal(illegal), .multicycle(multicycle),
        .mdu_start(mdu_start), .mdu_abort(mdu_abort)
    );

    alu_op_sequencer #(
        .OP_W(6), .ENABLE_M(0), .MUL_LAT(1), .DIV_LAT(1)
    ) u_dut_nom (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .alu_op(b_alu_op), .is_imm(b_is_imm), .funct7(b_funct7), .funct3(b_funct3),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .operation(b_operation), .illegal(b_illegal), .multicycle(b_multicycle),
        .mdu_start(b_mdu_start), .mdu_abort(b_mdu_abort)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference decode, straight from the op table ----------
    function automatic logic [4:0] base_of(input logic [2:0] f3);
        logic [4:0] r;
        case (f3)
            3'd0: r = 5'h02;  3'd1: r = 5'h04;  3'd2: r = 5'h08;  3'd3: r = 5'h09;
            3'd4: r = 5'h03;  3'd5: r = 5'h05;  3'd6: r = 5'h01;  default: r = 5'h00;
        endcase
        return r;
    endfunction

    task automatic ref_decode(input logic [1:0] aop, input logic imm, input logic [6:0] f7,
                              input logic [2:0] f3, input bit en_m,
                              output logic [4:0] code, output logic ill, output logic mc);
        ill  = 1'b0;
        code = 5'h02;
        if (aop == 2'd0) begin
            code = 5'h02;
        end else if (aop == 2'd3) begin
            code = 5'h0A;
        end else if (aop == 2'd1) begin
            ill  = (f3 == 3'd2 || f3 == 3'd3);
            code = {2'b10, f3};
        end else if (imm) begin
            code = base_of(f3);
            if (f3 == 3'd1) ill = (f7 != 7'h00);
            if (f3 == 3'd5) begin
                ill = (f7 != 7'h00 && f7 != 7'h20);
                if (f7 == 7'h20) code = 5'h07;
            end
        end else if (f7 == 7'h00) begin
            code = base_of(f3);
        end else if (f7 == 7'h20) begin
            ill  = !(f3 == 3'd0 || f3 == 3'd5);
            code = (f3 == 3'd0) ? 5'h06 : 5'h07;
        end else if (f7 == 7'h01 && en_m) begin
            code = {2'b11, f3};
        end else begin
            ill = 1'b1;
        end
        if (ill) code = 5'h02;
        mc = (code >= 5'h18);
    endtask

    // ---------------- transaction-level model of the main instance ----------
    bit         m_known = 1'b0;
    bit         m_valid, m_ill, m_mc, m_start, m_abort, m_pend;
    logic [4:0] m_op;
    int         m_due;
    int         cyc = 0;

    initial begin
        logic       exp_rdy;
        logic [4:0] c;
        logic       il, mc;
        int         lat;
        forever begin
            @(negedge clk);
            if (m_known) begin
                exp_rdy = !m_pend && (!m_valid || out_ready) && !flush;
                chk("in_ready",  32'(in_ready),  32'(exp_rdy));
                chk("out_valid", 32'(out_valid), 32'(m_valid));
                chk("mdu_start", 32'(mdu_start), 32'(m_start));
                chk("mdu_abort", 32'(mdu_abort), 32'(m_abort));
                if (m_valid) begin
                    chk("operation",  32'(operation),  32'(m_op));
                    chk("illegal",    32'(illegal),    32'(m_ill));
                    chk("multicycle", 32'(multicycle), 32'(m_mc));
                end
            end
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_known = 1'b1;
                m_valid = 1'b0; m_op = 5'h00; m_ill = 1'b0; m_mc = 1'b0;
                m_start = 1'b0; m_abort = 1'b0; m_pend = 1'b0;
            end else if (m_known) begin
                exp_rdy = !m_pend && (!m_valid || out_ready) && !flush;
                m_start = 1'b0;
                m_abort = 1'b0;
                if (flush) begin
                    m_abort = m_pend;
                    m_pend  = 1'b0;
                    m_valid = 1'b0;
                end else if (in_valid && exp_rdy) begin
                    ref_decode(alu_op, is_imm, funct7, funct3, 1'b1, c, il, mc);
                    m_op = c; m_ill = il; m_mc = mc;
                    if (mc) begin
                        lat     = c[2] ? DIV_LAT : MUL_LAT;
                        m_start = 1'b1;
                        if (lat == 1) begin
                            m_valid = 1'b1;
                        end else begin
                            m_valid = 1'b0;
                            m_pend  = 1'b1;
                            m_due   = cyc + lat - 1;   // result visible LAT edges after accept
                        end
                    end else begin
                        m_valid = 1'b1;
                    end
                end else if (m_pend) begin
                    if (cyc == m_due) begin
                        m_valid = 1'b1;
                        m_pend  = 1'b0;
                    end
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] aop, input logic imm, input logic [6:0] f7,
                         input logic [2:0] f3);
        in_valid = 1'b1;
        alu_op   = aop;
        is_imm   = imm;
        funct7   = f7;
        funct3   = f3;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] c;
        logic       il, mc;
        int         k;
        int         seen;
        int         r;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = 2'b00; is_imm = 1'b0; funct7 = 7'h00; funct3 = 3'h0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_is_imm = 1'b0;
        b_alu_op = 2'b00; b_funct7 = 7'h00; b_funct3 = 3'h0;

        // Pin the reference decode itself against the op table.
        ref_decode(2'b10, 1'b0, 7'h00, 3'b000, 1'b1, c, il, mc); chk("ref_add",  32'(c), 32'h02);
        ref_decode(2'b10, 1'b1, 7'h20, 3'b000, 1'b1, c, il, mc); chk("ref_addi", 32'(c), 32'h02);
        ref_decode(2'b10, 1'b1, 7'h20, 3'b101, 1'b1, c, il, mc); chk("ref_srai", 32'(c), 32'h07);
        ref_decode(2'b10, 1'b0, 7'h01, 3'b100, 1'b1, c, il, mc); chk("ref_div",  32'(c), 32'h1C);
        chk("ref_div_mc", 32'(mc), 1);
        ref_decode(2'b01, 1'b0, 7'h00, 3'b010, 1'b1, c, il, mc); chk("ref_br_ill", 32'(il), 1);
        ref_decode(2'b10, 1'b0, 7'h01, 3'b000, 1'b0, c, il, mc); chk("ref_nom_ill", 32'(il), 1);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_operation", 32'(operation), 0);
        chk("rst_mdu_abort", 32'(mdu_abort), 0);
        chk("rst_b_in_ready", 32'(b_in_ready), 1);

        // R-type ADD, latency 1.
        idle(1);
        drive(2'b10, 1'b0, 7'h00, 3'b000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("radd_valid", 32'(out_valid), 1);
        chk("radd_op",    32'(operation), 32'h02);
        chk("radd_ill",   32'(illegal),   0);

        // ADDI with bit 30 set stays ADD.
        idle(2);
        drive(2'b10, 1'b1, 7'h20, 3'b000);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("addi_op", 32'(operation), 32'h02);

        // SRAI.
        idle(2);
        drive(2'b10, 1'b1, 7'h20, 3'b101);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("srai_op", 32'(operation), 32'h07);

        // DIV: mdu_start at +1, result at +32.
        idle(2);
        drive(2'b10, 1'b0, 7'h01, 3'b100);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("div_start",    32'(mdu_start), 1);
        chk("div_in_ready", 32'(in_ready),  0);
        chk("div_valid_p1", 32'(out_valid), 0);
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        chk("div_latency", 32'(k), 32);
        chk("div_op",      32'(operation),  32'h1C);
        chk("div_mc",      32'(multicycle), 1);

        // DIVU flushed at +5: abort at +6, never valid.
        idle(2);
        drive(2'b10, 1'b0, 7'h01, 3'b101);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_abort",    32'(mdu_abort), 1);
        chk("flush_in_ready", 32'(in_ready),  1);
        @(negedge clk);
        chk("flush_abort_pulse", 32'(mdu_abort), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 0);

        // Back-pressure: XOR held 3 cycles, then OR accepted back-to-back.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(2'b10, 1'b0, 7'h00, 3'b100);
        @(posedge clk); #1;
        drive(2'b10, 1'b0, 7'h00, 3'b110);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 1);
            chk("hold_op",       32'(operation), 32'h03);
            chk("hold_in_ready", 32'(in_ready),  0);
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_op",    32'(operation), 32'h01);

        // RV32M disabled instance.
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_alu_op = 2'b10; b_is_imm = 1'b0; b_funct7 = 7'h01; b_funct3 = 3'b000;
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(negedge clk);
        chk("nom_valid", 32'(b_out_valid),  1);
        chk("nom_op",    32'(b_operation),  32'h02);
        chk("nom_ill",   32'(b_illegal),    1);
        chk("nom_mc",    32'(b_multicycle), 0);
        chk("nom_start", 32'(b_mdu_start),  0);
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_alu_op = 2'b01; b_funct3 = 3'b010; b_funct7 = 7'h00;
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(negedge clk);
        chk("nom_br_ill",   32'(b_illegal),   1);
        chk("nom_br_op",    32'(b_operation), 32'h02);
        chk("nom_abort",    32'(b_mdu_abort), 0);
        chk("nom_in_ready", 32'(b_in_ready),  1);

        // Randomised traffic against the model.
        @(posedge clk); #1;
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 499) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            r         = $urandom_range(0, 5);
            alu_op    = (r > 3) ? 2'b10 : 2'(r);
            is_imm    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0, 1:    funct7 = 7'h00;
                2:       funct7 = 7'h20;
                3:       funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            funct3 = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
